// File: rtl/bcd_updown_counter_if.sv
// Bus bundle for bcd_updown_counter: step/clear controls in,
// count and boundary flags out.
interface bcd_updown_counter_if #(
    parameter int NUM_DIGITS = 2
);
    logic                    i_up;
    logic                    i_down;
    logic                    i_clear;
    logic [4*NUM_DIGITS-1:0] o_digits;
    logic                    o_at_max;
    logic                    o_at_min;
    logic                    o_wrap;

    modport master (
        output i_up, i_down, i_clear,
        input  o_digits, o_at_max, o_at_min, o_wrap
    );

    modport slave (
        input  i_up, i_down, i_clear,
        output o_digits, o_at_max, o_at_min, o_wrap
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// Cascaded up/down digit counter with edge-triggered steps,
// optional saturation and optional hold-to-auto-repeat.
module bcd_updown_counter #(
    parameter int NUM_DIGITS    = 2,
    parameter int DIGIT_MAX     = 9,
    parameter int SATURATE      = 0,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    bcd_updown_counter_if.slave  io_bus
);

    localparam int C_HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                            REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW     = (C_HMAX < 1) ? 1 : $clog2(C_HMAX + 1);

    localparam logic [CW-1:0] C_RD_LAST =
        CW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [CW-1:0] C_RP_LAST =
        CW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
    localparam logic [3:0]    C_DMAX    = 4'(DIGIT_MAX);
    localparam bit            C_RPT_EN  = (REPEAT_DELAY > 0);
    localparam bit            C_SAT     = (SATURATE != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [CW-1:0]                 r_hold;
    logic [CW-1:0]                 w_hold_nxt;
    logic                          r_dir;
    logic                          w_dir_nxt;
    logic                          r_up_d;
    logic                          r_dn_d;
    logic [NUM_DIGITS-1:0][3:0]    r_digits;
    logic [NUM_DIGITS-1:0][3:0]    w_digits_nxt;
    logic [NUM_DIGITS-1:0][3:0]    w_inc;
    logic [NUM_DIGITS-1:0][3:0]    w_dec;
    logic [NUM_DIGITS:0]           w_cy;
    logic [NUM_DIGITS:0]           w_bw;
    logic                          r_wrap;
    logic                          w_wrap_nxt;
    logic                          w_up_req;
    logic                          w_dn_req;
    logic                          w_single;
    logic                          w_held;
    logic                          w_opp;
    logic                          w_abort;
    logic                          w_step;
    logic                          w_step_up;
    logic                          w_at_max;
    logic                          w_at_min;

    assign w_up_req = io_bus.i_up   & ~r_up_d;
    assign w_dn_req = io_bus.i_down & ~r_dn_d;
    assign w_single = w_up_req ^ w_dn_req;

    // r_dir names the direction being held while repeating.
    assign w_held  = r_dir ? io_bus.i_up : io_bus.i_down;
    assign w_opp   = r_dir ? w_dn_req : w_up_req;
    assign w_abort = io_bus.i_clear | ~w_held | w_opp;

    // Ripple chains: carry/borrow out of the top digit doubles
    // as the all-max / all-zero decode of the count register.
    assign w_cy[0] = 1'b1;
    assign w_bw[0] = 1'b1;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        assign w_inc[g] = !w_cy[g]               ? r_digits[g] :
                          (r_digits[g] == C_DMAX) ? 4'd0 :
                          r_digits[g] + 4'd1;
        assign w_dec[g] = !w_bw[g]               ? r_digits[g] :
                          (r_digits[g] == 4'd0)  ? C_DMAX :
                          r_digits[g] - 4'd1;
        assign w_cy[g+1] = w_cy[g] & (r_digits[g] == C_DMAX);
        assign w_bw[g+1] = w_bw[g] & (r_digits[g] == 4'd0);
    end

    assign w_at_max = w_cy[NUM_DIGITS];
    assign w_at_min = w_bw[NUM_DIGITS];

    // Edge-detect history; keeps tracking through clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_up_d <= 1'b0;
            r_dn_d <= 1'b0;
        end else begin
            r_up_d <= io_bus.i_up;
            r_dn_d <= io_bus.i_down;
        end
    end

    // Auto-repeat state, hold counter and held direction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hold  <= w_hold_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // Next auto-repeat state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!io_bus.i_clear && w_single && C_RPT_EN)
                    w_next = S_DELAY;
            end
            S_DELAY: begin
                if (w_abort)
                    w_next = S_IDLE;
                else if (r_hold == C_RD_LAST)
                    w_next = S_REPEAT;
            end
            S_REPEAT: begin
                if (w_abort)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Step strobe, step direction and hold-counter update.
    always_comb begin
        w_step     = 1'b0;
        w_step_up  = r_dir;
        w_hold_nxt = '0;
        w_dir_nxt  = r_dir;
        case (r_state)
            S_IDLE: begin
                if (!io_bus.i_clear && w_single) begin
                    w_step    = 1'b1;
                    w_step_up = w_up_req;
                    w_dir_nxt = w_up_req;
                end
            end
            S_DELAY: begin
                if (!w_abort) begin
                    if (r_hold == C_RD_LAST)
                        w_step = 1'b1;
                    else
                        w_hold_nxt = r_hold + CW'(1);
                end
            end
            S_REPEAT: begin
                if (!w_abort) begin
                    if (r_hold == C_RP_LAST)
                        w_step = 1'b1;
                    else
                        w_hold_nxt = r_hold + CW'(1);
                end
            end
            default: ;
        endcase
    end

    // Next count and wrap flag; clear beats any step.
    always_comb begin
        w_digits_nxt = r_digits;
        w_wrap_nxt   = 1'b0;
        if (io_bus.i_clear) begin
            w_digits_nxt = '0;
        end else if (w_step) begin
            if (w_step_up) begin
                if (!(w_at_max && C_SAT))
                    w_digits_nxt = w_inc;
                w_wrap_nxt = w_at_max && !C_SAT;
            end else begin
                if (!(w_at_min && C_SAT))
                    w_digits_nxt = w_dec;
                w_wrap_nxt = w_at_min && !C_SAT;
            end
        end
    end

    // Count and wrap-pulse registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_digits <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_digits <= w_digits_nxt;
            r_wrap   <= w_wrap_nxt;
        end
    end

    assign io_bus.o_digits = r_digits;
    assign io_bus.o_at_max = w_at_max;
    assign io_bus.o_at_min = w_at_min;
    assign io_bus.o_wrap   = r_wrap;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: four configurations share one
// stimulus stream and are checked against an integer-count model.
module tb_bcd_updown_counter;

    localparam int NI = 4;
    localparam int PD [NI]  = '{9, 9, 9, 15};
    localparam int PS [NI]  = '{0, 1, 0, 0};
    localparam int PRD [NI] = '{0, 0, 4, 3};
    localparam int PRP [NI] = '{1, 1, 2, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up  = 1'b0;
    logic dn  = 1'b0;
    logic clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] dg  [NI];
    logic       amx [NI];
    logic       amn [NI];
    logic       wr  [NI];

    bcd_updown_counter_if #(.NUM_DIGITS(2)) bus0 ();
    bcd_updown_counter_if #(.NUM_DIGITS(2)) bus1 ();
    bcd_updown_counter_if #(.NUM_DIGITS(2)) bus2 ();
    bcd_updown_counter_if #(.NUM_DIGITS(2)) bus3 ();

    assign bus0.i_up = up;  assign bus0.i_down = dn;  assign bus0.i_clear = clr;
    assign bus1.i_up = up;  assign bus1.i_down = dn;  assign bus1.i_clear = clr;
    assign bus2.i_up = up;  assign bus2.i_down = dn;  assign bus2.i_clear = clr;
    assign bus3.i_up = up;  assign bus3.i_down = dn;  assign bus3.i_clear = clr;

    assign dg[0] = bus0.o_digits; assign amx[0] = bus0.o_at_max;
    assign amn[0] = bus0.o_at_min; assign wr[0] = bus0.o_wrap;
    assign dg[1] = bus1.o_digits; assign amx[1] = bus1.o_at_max;
    assign amn[1] = bus1.o_at_min; assign wr[1] = bus1.o_wrap;
    assign dg[2] = bus2.o_digits; assign amx[2] = bus2.o_at_max;
    assign amn[2] = bus2.o_at_min; assign wr[2] = bus2.o_wrap;
    assign dg[3] = bus3.o_digits; assign amx[3] = bus3.o_at_max;
    assign amn[3] = bus3.o_at_min; assign wr[3] = bus3.o_wrap;

    bcd_updown_counter #(
        .NUM_DIGITS(2), .DIGIT_MAX(9), .SATURATE(0),
        .REPEAT_DELAY(0), .REPEAT_PERIOD(1)
    ) u0 (.i_clk(clk), .i_rst(rst), .io_bus(bus0.slave));

    bcd_updown_counter #(
        .NUM_DIGITS(2), .DIGIT_MAX(9), .SATURATE(1),
        .REPEAT_DELAY(0), .REPEAT_PERIOD(1)
    ) u1 (.i_clk(clk), .i_rst(rst), .io_bus(bus1.slave));

    bcd_updown_counter #(
        .NUM_DIGITS(2), .DIGIT_MAX(9), .SATURATE(0),
        .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
    ) u2 (.i_clk(clk), .i_rst(rst), .io_bus(bus2.slave));

    bcd_updown_counter #(
        .NUM_DIGITS(2), .DIGIT_MAX(15), .SATURATE(0),
        .REPEAT_DELAY(3), .REPEAT_PERIOD(1)
    ) u3 (.i_clk(clk), .i_rst(rst), .io_bus(bus3.slave));

    always #5 clk = ~clk;

    // Model: count as a plain integer in base (DIGIT_MAX+1), and
    // auto-repeat as "steps at hold lengths 0, RD, RD+k*RP".
    int m_cnt  [NI];
    int m_hold [NI];
    bit m_act  [NI];
    bit m_dir  [NI];
    bit m_pu   [NI];
    bit m_pd   [NI];
    bit m_wrap [NI];
    bit m_ok = 1'b0;

    always @(posedge clk) begin
        for (int j = 0; j < NI; j++) begin
            int  b;
            int  r;
            bit  ur;
            bit  dr;
            bit  stp;
            bit  sdir;
            b = PD[j] + 1;
            r = b * b;
            if (rst) begin
                m_cnt[j]  = 0;
                m_wrap[j] = 1'b0;
                m_pu[j]   = 1'b0;
                m_pd[j]   = 1'b0;
                m_act[j]  = 1'b0;
                m_hold[j] = 0;
                m_dir[j]  = 1'b0;
                m_ok      = 1'b1;
            end else begin
                ur = up && !m_pu[j];
                dr = dn && !m_pd[j];
                stp = 1'b0;
                sdir = 1'b0;
                m_wrap[j] = 1'b0;
                if (clr) begin
                    m_cnt[j] = 0;
                    m_act[j] = 1'b0;
                end else if (m_act[j]) begin
                    if ((m_dir[j] ? !up : !dn) || (m_dir[j] ? dr : ur)) begin
                        m_act[j] = 1'b0;
                    end else begin
                        m_hold[j]++;
                        if (m_hold[j] == PRD[j] ||
                            (m_hold[j] > PRD[j] &&
                             (m_hold[j] - PRD[j]) % PRP[j] == 0)) begin
                            stp = 1'b1;
                            sdir = m_dir[j];
                        end
                    end
                end else if (ur != dr) begin
                    stp = 1'b1;
                    sdir = ur;
                    if (PRD[j] > 0) begin
                        m_act[j]  = 1'b1;
                        m_hold[j] = 0;
                        m_dir[j]  = ur;
                    end
                end
                if (stp) begin
                    if (sdir) begin
                        if (m_cnt[j] == r - 1) begin
                            if (PS[j] == 0) begin
                                m_cnt[j] = 0;
                                m_wrap[j] = 1'b1;
                            end
                        end else begin
                            m_cnt[j]++;
                        end
                    end else begin
                        if (m_cnt[j] == 0) begin
                            if (PS[j] == 0) begin
                                m_cnt[j] = r - 1;
                                m_wrap[j] = 1'b1;
                            end
                        end else begin
                            m_cnt[j]--;
                        end
                    end
                end
                m_pu[j] = up;
                m_pd[j] = dn;
            end
        end
    end

    // Per-cycle compare of every instance against the model.
    always @(negedge clk) begin
        if (m_ok) begin
            for (int j = 0; j < NI; j++) begin
                int         b;
                logic [7:0] e_dg;
                logic       e_mx;
                logic       e_mn;
                b = PD[j] + 1;
                e_dg = {4'(m_cnt[j] / b), 4'(m_cnt[j] % b)};
                e_mx = (m_cnt[j] == b * b - 1);
                e_mn = (m_cnt[j] == 0);
                n_cmp++;
                if (dg[j] !== e_dg || amx[j] !== e_mx ||
                    amn[j] !== e_mn || wr[j] !== m_wrap[j]) begin
                    n_bad++;
                    $display("FAIL model[%0d] t=%0t got d=%h mx=%b mn=%b w=%b exp d=%h mx=%b mn=%b w=%b",
                             j, $time, dg[j], amx[j], amn[j], wr[j],
                             e_dg, e_mx, e_mn, m_wrap[j]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic pulse_up(input int n);
        repeat (n) begin
            up = 1'b1;
            @(negedge clk);
            up = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_clear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    logic [7:0] rpt_exp [10] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02,
                                 8'h02, 8'h03, 8'h03, 8'h04, 8'h04};

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_digits", dg[0], 8'h00);
        chk("rst_at_min", {7'd0, amn[0]}, 8'd1);
        chk("rst_at_max", {7'd0, amx[0]}, 8'd0);
        chk("rst_wrap",   {7'd0, wr[0]},  8'd0);
        rst = 1'b0;

        pulse_up(9);
        chk("pre_carry", dg[0], 8'h09);
        up = 1'b1;
        @(negedge clk);
        chk("carry_09_10", dg[0], 8'h10);
        chk("carry_wrap0", {7'd0, wr[0]}, 8'd0);
        up = 1'b0;
        @(negedge clk);
        pulse_up(5);
        chk("hex_0f", dg[3], 8'h0F);
        pulse_up(1);
        chk("hex_carry", dg[3], 8'h10);

        do_clear();
        dn = 1'b1;
        @(negedge clk);
        chk("wrap_dn", dg[0], 8'h99);
        chk("wrap_dn_pulse", {7'd0, wr[0]}, 8'd1);
        chk("sat_min_hold", dg[1], 8'h00);
        dn = 1'b0;
        @(negedge clk);
        chk("wrap_dn_end", {7'd0, wr[0]}, 8'd0);

        do_clear();
        pulse_up(99);
        chk("sat_99", dg[1], 8'h99);
        chk("sat_at_max", {7'd0, amx[1]}, 8'd1);
        up = 1'b1;
        @(negedge clk);
        chk("sat_hold", dg[1], 8'h99);
        chk("sat_nowrap", {7'd0, wr[1]}, 8'd0);
        chk("wrap_up", dg[0], 8'h00);
        chk("wrap_up_pulse", {7'd0, wr[0]}, 8'd1);
        up = 1'b0;
        @(negedge clk);
        chk("wrap_up_end", {7'd0, wr[0]}, 8'd0);

        do_clear();
        pulse_up(42);
        chk("pre_both", dg[0], 8'h42);
        up = 1'b1;
        dn = 1'b1;
        @(negedge clk);
        chk("both_edges", dg[0], 8'h42);
        up = 1'b0;
        dn = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        up = 1'b1;
        @(negedge clk);
        chk("clr_vs_up", dg[0], 8'h00);
        clr = 1'b0;
        @(negedge clk);
        chk("held_thru_clr", dg[0], 8'h00);
        up = 1'b0;
        @(negedge clk);

        up = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("repeat_e%0d", k + 1), dg[2], rpt_exp[k]);
        end
        up = 1'b0;
        @(negedge clk);
        chk("repeat_stop", dg[2], 8'h04);
        @(negedge clk);

        do_clear();
        up = 1'b1;
        repeat (3) @(negedge clk);
        dn = 1'b1;
        repeat (3) @(negedge clk);
        chk("opp_abort2", dg[2], 8'h01);
        chk("opp_abort3", dg[3], 8'h01);
        up = 1'b0;
        repeat (7) @(negedge clk);
        dn = 1'b0;
        @(negedge clk);

        do_clear();
        up = 1'b1;
        repeat (6) @(negedge clk);
        chk("rpt3_run", dg[3], 8'h04);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_rpt", dg[3], 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_new_edge", dg[3], 8'h01);
        up = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_idle", dg[3], 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter NUM_DIGITS, default 2: number of cascaded digits, legal range 1..8.
REQ-002 Parameter DIGIT_MAX, default 9: highest value of each digit, legal range 1..15 (9 = decimal, 15 = hex).
REQ-003 Parameter SATURATE, default 0: 0 = full-range wrap-around, 1 = hold at the limits.
REQ-004 Parameter REPEAT_DELAY, default 0: hold cycles before auto-repeat starts; 0 disables auto-repeat.
REQ-005 Parameter REPEAT_PERIOD, default 1: cycles between auto-repeat steps, legal range >= 1.
REQ-006 Clock and reset are decided: one clock; reset is synchronous and active-high.
REQ-007 i_clk  input  1  system clock; all state changes on the rising edge.
REQ-008 i_rst  input  1  synchronous active-high reset.
REQ-009 i_up  input  1  debounced increment level.
REQ-010 i_down  input  1  debounced decrement level.
REQ-011 i_clear  input  1  synchronous clear of the count to all zeros.
REQ-012 o_digits  output  4*NUM_DIGITS  count, one 4-bit digit per nibble; digit 0 (least significant) is in bits [3:0].
REQ-013 o_at_max  output  1  high while every digit equals DIGIT_MAX.
REQ-014 o_at_min  output  1  high while every digit equals 0.
REQ-015 o_wrap  output  1  single-cycle pulse on any full-range wrap.

Function
REQ-016 Edge detection: i_up and i_down SHALL be registered each cycle, and a step request SHALL fire when the input is 1 and its registered copy is 0.
REQ-017 Step latency: o_digits SHALL show the new count on the first rising edge at which the step request is true, i.e. one clock after i_up or i_down is first sampled high.
REQ-018 Up step: digit 0 increments; a digit at DIGIT_MAX SHALL go to 0 and carry into the next digit; the ripple completes in the same cycle.
REQ-019 Down step: digit 0 decrements; a digit at 0 SHALL go to DIGIT_MAX and borrow from the next digit; the ripple completes in the same cycle.
REQ-020 Upper boundary: up step with o_at_max=1:
- SATURATE=0: count goes to all zeros and o_wrap pulses for one cycle, aligned with the new count.
- SATURATE=1: count holds and o_wrap stays 0.
REQ-021 Lower boundary: down step with o_at_min=1:
- SATURATE=0: count goes to all DIGIT_MAX and o_wrap pulses for one cycle.
- SATURATE=1: count holds.
REQ-022 Simultaneous events: if up and down step requests are both true in one cycle, neither step SHALL happen.
REQ-023 Auto-repeat state machine (REPEAT_DELAY>0), states IDLE, DELAY, REPEAT:
- IDLE -> DELAY on a single-direction step request; the hold counter is cleared.
- DELAY -> REPEAT after REPEAT_DELAY cycles of continuous hold, with one additional step.
- In REPEAT, one step every REPEAT_PERIOD cycles.
REQ-024 Auto-repeat abort: the state machine SHALL return to IDLE, with no step, when the held input drops, the opposite input rises, or i_clear is asserted.
REQ-025 Auto-repeat steps SHALL obey REQ-018 to REQ-021, including saturation and o_wrap.
REQ-026 Hold counter width: ceil(log2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)) bits, and it SHALL never overflow.
REQ-027 Clear priority: i_clear SHALL take priority over any step and set the count to 0 on the next edge.
REQ-028 The edge-detect registers SHALL keep updating during i_clear, so a level held through clear produces no step when clear releases.
REQ-029 Flag timing: o_at_max and o_at_min SHALL be decoded from the count register and change in the same cycle as o_digits.
REQ-030 No digit SHALL ever hold a value above DIGIT_MAX.

Reset
REQ-031 While i_rst=1 at a rising edge, the block SHALL set o_digits=0, o_wrap=0, the state machine to IDLE, the hold counter to 0 and both edge-detect registers to 0.
REQ-032 Reset values give o_at_min=1 and o_at_max=0.
REQ-033 Reset SHALL take priority over i_clear and over step requests.
REQ-034 Reset asserted mid-repeat SHALL abort the repeat; an input still high at reset release counts as a new rising edge.

Verification
REQ-035 Carry (NUM_DIGITS=2, DIGIT_MAX=9, SATURATE=0): count 09, one i_up pulse -> 10 on the next edge, o_wrap=0.
REQ-036 Wrap: count 99, i_up pulse -> 00, o_wrap=1 for exactly one cycle; count 00, i_down pulse -> 99, o_wrap=1 for one cycle.
REQ-037 Saturate (SATURATE=1): count 99, i_up pulse -> count stays 99, o_at_max=1, o_wrap=0.
REQ-038 Simultaneous edges: count 42, i_up and i_down rise on the same cycle -> count stays 42; i_clear on the same cycle as an i_up edge -> 00.
REQ-039 Auto-repeat (REPEAT_DELAY=4, REPEAT_PERIOD=2): i_up held 10 cycles from 00 -> 01 at edge 1, 02 at edge 5, then 03 at edge 7 and 04 at edge 9, stopping on release.
REQ-040 Hex (DIGIT_MAX=15): count 0F, i_up pulse -> 10 on the next edge; i_rst asserted mid-repeat -> 00 and IDLE on the next edge.
